// File: rtl/lcd_text_driver.sv
// HD44780 8-bit text driver: power-on init, then endless refresh of two 16-char lines from char_in.
// Define LCD_FRAME_DONE_EN to get a one-clk frame_done pulse on the last character's ELO tick.
`timescale 1ns/1ps
module lcd_text_driver #(
    parameter int TICK_DIV  = 50000,
    parameter int PWR_TICKS = 20,
    parameter int CLR_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       frame_done
);

    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_MAX = (PWR_TICKS > CLR_TICKS) ? PWR_TICKS : CLR_TICKS;
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [WAIT_W-1:0] PWR_LAST  = WAIT_W'(PWR_TICKS - 1);
    localparam logic [WAIT_W-1:0] CLR_LAST  = WAIT_W'(CLR_TICKS - 1);

    typedef enum logic [3:0] {
        S_PWR_WAIT, S_FUNC_SET, S_DISP_ON, S_ENTRY, S_CLEAR,
        S_CLR_WAIT, S_LINE1, S_CHARS1, S_LINE2, S_CHARS2
    } state_t;

    typedef enum logic [1:0] {PH_ADDR, PH_SETUP, PH_EHI, PH_ELO} phase_t;

    state_t            r_state, w_stateNext;
    phase_t            r_phase, w_phaseNext;
    logic [CNT_W-1:0]  r_tickCnt;
    logic [WAIT_W-1:0] r_wait, w_waitNext;
    logic [3:0]        r_col, w_colNext;
    logic [4:0]        r_index, w_indexNext;
    logic [7:0]        r_data, w_dataNext;
    logic              r_rs, w_rsNext;
    logic              r_e, w_eNext;
    logic              w_tick;
    logic              w_isData;
    logic [7:0]        w_cmdByte;
    logic [3:0]        w_colInc;

    assign w_tick   = (r_tickCnt == TICK_LAST);
    assign w_isData = (r_state == S_CHARS1) || (r_state == S_CHARS2);
    assign w_colInc = r_col + 4'd1;

    always_comb begin
        case (r_state)
            S_FUNC_SET: w_cmdByte = 8'h38;
            S_DISP_ON:  w_cmdByte = 8'h0C;
            S_ENTRY:    w_cmdByte = 8'h06;
            S_CLEAR:    w_cmdByte = 8'h01;
            S_LINE2:    w_cmdByte = 8'hC0;
            default:    w_cmdByte = 8'h80;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tickCnt <= '0;
            r_state   <= S_PWR_WAIT;
            r_phase   <= PH_ADDR;
            r_wait    <= '0;
            r_col     <= '0;
            r_index   <= '0;
            r_data    <= 8'h00;
            r_rs      <= 1'b0;
            r_e       <= 1'b0;
        end else begin
            r_tickCnt <= w_tick ? '0 : r_tickCnt + 1'b1;
            r_state   <= w_stateNext;
            r_phase   <= w_phaseNext;
            r_wait    <= w_waitNext;
            r_col     <= w_colNext;
            r_index   <= w_indexNext;
            r_data    <= w_dataNext;
            r_rs      <= w_rsNext;
            r_e       <= w_eNext;
        end
    end

    // Outputs are registered; each tick loads the values of the phase being entered.
    always_comb begin
        w_stateNext = r_state;
        w_phaseNext = r_phase;
        w_waitNext  = r_wait;
        w_colNext   = r_col;
        w_indexNext = r_index;
        w_dataNext  = r_data;
        w_rsNext    = r_rs;
        w_eNext     = r_e;
        if (w_tick) begin
            case (r_state)
                S_PWR_WAIT: begin
                    if (r_wait == PWR_LAST) begin
                        w_stateNext = S_FUNC_SET;
                        w_waitNext  = '0;
                    end else begin
                        w_waitNext = r_wait + 1'b1;
                    end
                end
                S_CLR_WAIT: begin
                    if (r_wait == CLR_LAST) begin
                        w_stateNext = S_LINE1;
                        w_waitNext  = '0;
                        w_indexNext = 5'd0;
                    end else begin
                        w_waitNext = r_wait + 1'b1;
                    end
                end
                default: begin
                    case (r_phase)
                        PH_ADDR: begin
                            w_phaseNext = PH_SETUP;
                            w_rsNext    = w_isData;
                            w_dataNext  = w_isData ? char_in : w_cmdByte;
                        end
                        PH_SETUP: begin
                            w_phaseNext = PH_EHI;
                            w_eNext     = 1'b1;
                        end
                        PH_EHI: begin
                            w_phaseNext = PH_ELO;
                            w_eNext     = 1'b0;
                        end
                        default: begin
                            w_phaseNext = PH_ADDR;
                            // Index moves only when entering a data transfer or the line-1 home.
                            case (r_state)
                                S_FUNC_SET: w_stateNext = S_DISP_ON;
                                S_DISP_ON:  w_stateNext = S_ENTRY;
                                S_ENTRY:    w_stateNext = S_CLEAR;
                                S_CLEAR: begin
                                    w_stateNext = (CLR_TICKS == 0) ? S_LINE1 : S_CLR_WAIT;
                                    w_indexNext = 5'd0;
                                end
                                S_LINE1: begin
                                    w_stateNext = S_CHARS1;
                                    w_colNext   = 4'd0;
                                    w_indexNext = 5'd0;
                                end
                                S_CHARS1: begin
                                    if (r_col == 4'd15) begin
                                        w_stateNext = S_LINE2;
                                    end else begin
                                        w_colNext   = w_colInc;
                                        w_indexNext = {1'b0, w_colInc};
                                    end
                                end
                                S_LINE2: begin
                                    w_stateNext = S_CHARS2;
                                    w_colNext   = 4'd0;
                                    w_indexNext = 5'd16;
                                end
                                S_CHARS2: begin
                                    if (r_col == 4'd15) begin
                                        w_stateNext = S_LINE1;
                                        w_indexNext = 5'd0;
                                    end else begin
                                        w_colNext   = w_colInc;
                                        w_indexNext = {1'b1, w_colInc};
                                    end
                                end
                                default: w_stateNext = S_PWR_WAIT;
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    assign index    = r_index;
    assign lcd_rs   = r_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = r_e;
    assign lcd_data = r_data;

`ifdef LCD_FRAME_DONE_EN
    assign frame_done = !rst && w_tick && (r_state == S_CHARS2) &&
                        (r_phase == PH_ELO) && (r_col == 4'd15);
`else
    assign frame_done = 1'b0;
`endif

endmodule
